ma_mem_access_controller: RTL and testbench
===========================================

Name: ma_mem_access_controller

Overview:
- Sequences the memory-access (MA) stage of the RV32IM pipeline.
- Takes the memory-control and operand fields held in the EX/MA pipeline register and runs one request/acknowledge transaction per load or store against a variable-latency data memory.
- Generates byte strobes, sign- or zero-extends load data, and drives a stall that freezes the EX/MA register and all upstream stages until the access completes.
- Detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum ACCESS-state cycles to wait for mem_ack before aborting.
- TO_WIDTH, 8: width of the timeout counter; must satisfy 2^TO_WIDTH > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- mem_read  in  1  load in MA stage (from EX/MA register).
- mem_write  in  1  store in MA stage.
- func_3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALU_out  in  32  effective byte address.
- DATA_2  in  32  store data (rs2).
- mem_ack  in  1  memory completion, valid only in ACCESS.
- mem_rdata  in  32  memory read word, valid with mem_ack.
- mem_req  out  1  registered request, held until ack or timeout.
- mem_we  out  1  registered write enable.
- mem_addr  out  32  registered word address, {ALU_out[31:2],2'b00}.
- mem_wdata  out  32  registered lane-replicated store data.
- mem_wstrb  out  4  registered byte strobes (0000 for loads).
- stall  out  1  combinational; freezes PC, IF/ID, ID/EX, EX/MA.
- load_data  out  32  extended load result for MA/WB.
- load_valid  out  1  one-cycle pulse when load_data is valid.
- misaligned_fault  out  1  one-cycle pulse.
- bus_error  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset: state IDLE, timeout counter 0. All registered outputs are 0. stall=0 while RESET=1.
- Reset mid-transaction: mem_req drops at the next edge and any pending ack is ignored.
- op = mem_read | mem_write. When both are set, the write takes priority and the read is ignored.
- Misaligned or illegal access, fault = any of:
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
  - func_3 ∈ {011,110,111}.
  - Store with func_3 ∈ {100,101}.
- FSM IDLE:
  - If op and not fault: stall=1; load mem_req=1, mem_we, mem_addr, mem_wdata, mem_wstrb; go to ACCESS; clear the counter.
  - If op and fault: no request, stall=0, misaligned_fault=1 next cycle, load_data=0; remain IDLE.
- FSM ACCESS:
  - stall=1 and the counter increments each cycle.
  - On mem_ack=1: mem_req/mem_we/mem_wstrb cleared. For a load, load_data is the extended lane and load_valid=1 next cycle. Go to DONE.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack: drop the request, bus_error=1 next cycle, load_data=0, load_valid=0, go to DONE.
- FSM DONE: stall=0 so the pipeline advances one instruction; return to IDLE. Pulses last exactly this cycle.
- Minimum MA occupancy per memory op is 3 cycles (ack in first ACCESS cycle). Non-memory instructions take 1 cycle and never stall.
- mem_ack outside ACCESS is ignored.
- Store formatting:
  - SB: wstrb = 0001 << addr[1:0]; wdata = {4{DATA_2[7:0]}}.
  - SH: wstrb = addr[1] ? 1100 : 0011; wdata = {2{DATA_2[15:0]}}.
  - SW: wstrb = 1111; wdata = DATA_2.
- Load formatting: select the byte by addr[1:0] or the halfword by addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through. The address is captured with the request, not re-read from ALU_out.

Decomposition:
- Shared package (mem_ctrl_pkg) holds:
  - func_3 constants F3_B/H/W/BU/HU.
  - FSM state encoding: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
- One natural sub-module, load_store_formatter: combinational; produces wstrb/wdata from (func_3, addr[1:0], DATA_2) and extended load data from (func_3, addr[1:0], rdata).

Test Plan:
- LW addr 0x100, ack after 2 ACCESS cycles, rdata 0xDEADBEEF -> stall high 4 cycles, mem_addr 0x100, wstrb 0000; load_data 0xDEADBEEF with load_valid 1 for one cycle.
- LB addr 0x203, rdata 0x80123456 -> load_data 0xFFFFFF80. LBU same -> 0x00000080.
- SH addr 0x102, DATA_2 0x1234ABCD -> mem_we 1, wstrb 1100, wdata 0xABCDABCD, mem_addr 0x100.
- LW addr 0x101 -> no mem_req; misaligned_fault pulse; stall never asserted.
- TIMEOUT_CYCLES=4, SW without ack -> mem_req high exactly 4 cycles; bus_error pulse; stall released in DONE.
- RESET asserted in ACCESS, then a late ack -> mem_req 0 next edge, state IDLE, no load_valid. Back-to-back LW/SW with immediate acks -> 3 cycles each, no lost or duplicated request.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared access-size codes, MA FSM encoding and the access legality check.
package mem_ctrl_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;
    // Unsigned sizes exist only for loads; unused func_3 codes are always illegal.
    function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] a, input logic wr);
        return (f3 == F3_B)  ? 1'b0 :
               (f3 == F3_H)  ? a[0] :
               (f3 == F3_W)  ? |a :
               (f3 == F3_BU) ? wr :
               (f3 == F3_HU) ? (wr | a[0]) : 1'b1;
    endfunction
endpackage

// File: rtl/load_store_formatter.sv
// load_store_formatter: byte strobes, lane-replicated store data and extended load data.
module load_store_formatter
    import mem_ctrl_pkg::*;
(
    input  logic [2:0]  func_3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b     = rdata[{addr_lo, 3'b000} +: 8];
        h     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        wstrb = (func_3 == F3_B) ? (4'b0001 << addr_lo) :
                (func_3 == F3_H) ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata = (func_3 == F3_B) ? {4{wdata_in[7:0]}} :
                (func_3 == F3_H) ? {2{wdata_in[15:0]}} : wdata_in;
        ldata = (func_3 == F3_B)  ? {{24{b[7]}}, b} :
                (func_3 == F3_BU) ? {24'b0, b} :
                (func_3 == F3_H)  ? {{16{h[15]}}, h} :
                (func_3 == F3_HU) ? {16'b0, h} : rdata;
    end
endmodule

// File: rtl/ma_mem_access_controller.sv
// ma_mem_access_controller: MA-stage req/ack sequencer with stall, extension, misalign and timeout detection.
module ma_mem_access_controller
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_WIDTH       = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func_3,
    input  logic [31:0] ALU_out,
    input  logic [31:0] DATA_2,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misaligned_fault,
    output logic        bus_error
);
    state_t              state_q, state_d;
    logic [TO_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]          f3_q, f3_d;
    logic [1:0]          alo_q, alo_d;
    logic                ld_q, ld_d;
    logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0]         mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_wstrb_q, mem_wstrb_d;
    logic [31:0]         load_data_q, load_data_d;
    logic                load_valid_q, load_valid_d, misaligned_fault_q, misaligned_fault_d;
    logic                bus_error_q, bus_error_d;
    logic                op, fault, start, flt, ack_hit, tmo, fin;
    logic [3:0]          f_wstrb;
    logic [31:0]         f_wdata, f_ldata;
    assign op      = mem_read | mem_write;
    assign fault   = access_fault(func_3, ALU_out[1:0], mem_write);
    assign start   = (state_q == IDLE) && op && !fault;
    assign flt     = (state_q == IDLE) && op && fault;
    assign ack_hit = (state_q == ACCESS) && mem_ack;
    assign tmo     = (state_q == ACCESS) && !mem_ack && (cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1));
    assign fin     = ack_hit | tmo;
    // Live fields format the store at launch; captured fields extend the load at ack.
    load_store_formatter u_fmt (
        .func_3   (state_q == IDLE ? func_3 : f3_q),
        .addr_lo  (state_q == IDLE ? ALU_out[1:0] : alo_q),
        .wdata_in (DATA_2),
        .rdata    (mem_rdata),
        .wstrb    (f_wstrb),
        .wdata    (f_wdata),
        .ldata    (f_ldata)
    );
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q            <= IDLE;
            cnt_q              <= '0;
            f3_q               <= '0;
            alo_q              <= '0;
            ld_q               <= 1'b0;
            mem_req_q          <= 1'b0;
            mem_we_q           <= 1'b0;
            mem_addr_q         <= '0;
            mem_wdata_q        <= '0;
            mem_wstrb_q        <= '0;
            load_data_q        <= '0;
            load_valid_q       <= 1'b0;
            misaligned_fault_q <= 1'b0;
            bus_error_q        <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            f3_q               <= f3_d;
            alo_q              <= alo_d;
            ld_q               <= ld_d;
            mem_req_q          <= mem_req_d;
            mem_we_q           <= mem_we_d;
            mem_addr_q         <= mem_addr_d;
            mem_wdata_q        <= mem_wdata_d;
            mem_wstrb_q        <= mem_wstrb_d;
            load_data_q        <= load_data_d;
            load_valid_q       <= load_valid_d;
            misaligned_fault_q <= misaligned_fault_d;
            bus_error_q        <= bus_error_d;
        end
    end
    always_comb begin
        state_d = (state_q == IDLE)   ? (start ? ACCESS : IDLE) :
                  (state_q == ACCESS) ? (fin ? DONE : ACCESS) : IDLE;
    end
    always_comb begin
        stall              = !RESET && (start || state_q == ACCESS);
        cnt_d              = start ? '0 : (state_q == ACCESS) ? cnt_q + TO_WIDTH'(1) : cnt_q;
        f3_d               = start ? func_3 : f3_q;
        alo_d              = start ? ALU_out[1:0] : alo_q;
        ld_d               = start ? !mem_write : ld_q;
        mem_req_d          = start ? 1'b1 : fin ? 1'b0 : mem_req_q;
        mem_we_d           = start ? mem_write : fin ? 1'b0 : mem_we_q;
        mem_wstrb_d        = start ? (mem_write ? f_wstrb : 4'b0000) : fin ? 4'b0000 : mem_wstrb_q;
        mem_addr_d         = start ? {ALU_out[31:2], 2'b00} : mem_addr_q;
        mem_wdata_d        = start ? (mem_write ? f_wdata : 32'h0) : mem_wdata_q;
        load_valid_d       = ack_hit && ld_q;
        misaligned_fault_d = flt;
        bus_error_d        = tmo;
        load_data_d        = (ack_hit && ld_q) ? f_ldata : (flt || tmo) ? 32'h0 : load_data_q;
    end
    assign mem_req          = mem_req_q;
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;
    assign mem_wstrb        = mem_wstrb_q;
    assign load_data        = load_data_q;
    assign load_valid       = load_valid_q;
    assign misaligned_fault = misaligned_fault_q;
    assign bus_error        = bus_error_q;
endmodule

// File: tb/tb_ma_mem_access_controller.sv
// tb_ma_mem_access_controller: transaction-level model of the MA stage, compared every cycle, plus literal pins.
module tb_ma_mem_access_controller;
    localparam int T = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0, mem_ack = 1'b0;
    logic [2:0]  func_3 = 3'b0;
    logic [31:0] alu_out = 32'h0, data_2 = 32'h0, mem_rdata = 32'h0;
    logic        mem_req, mem_we, stall, load_valid, misaligned_fault, bus_error;
    logic [31:0] mem_addr, mem_wdata, load_data;
    logic [3:0]  mem_wstrb;

    ma_mem_access_controller #(.TIMEOUT_CYCLES(T), .TO_WIDTH(3)) dut (
        .CLK(clk), .RESET(rst), .mem_read(mem_read), .mem_write(mem_write), .func_3(func_3),
        .ALU_out(alu_out), .DATA_2(data_2), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .misaligned_fault(misaligned_fault), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit chk_en = 1'b0;
    logic        e_stall, e_req, e_we, e_lv, e_mf, e_be, e_ldchk;
    logic [31:0] e_addr, e_wdata, e_ld;
    logic [3:0]  e_wstrb;
    bit pend_mf = 1'b0;
    int stall_cnt = 0, req_cnt = 0, lv_cnt = 0, mf_cnt = 0, be_cnt = 0;
    logic [31:0] cap_ld, cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic        cap_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(e_stall));
            chk("mem_req", 32'(mem_req), 32'(e_req));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
            chk("load_valid", 32'(load_valid), 32'(e_lv));
            chk("misaligned_fault", 32'(misaligned_fault), 32'(e_mf));
            chk("bus_error", 32'(bus_error), 32'(e_be));
            if (e_req) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wdata", mem_wdata, e_wdata);
            end
            if (e_ldchk) chk("load_data", load_data, e_ld);
        end
        stall_cnt += int'(stall);
        req_cnt   += int'(mem_req);
        lv_cnt    += int'(load_valid);
        mf_cnt    += int'(misaligned_fault);
        be_cnt    += int'(bus_error);
        if (load_valid) cap_ld = load_data;
        if (mem_req) begin
            cap_addr = mem_addr; cap_wdata = mem_wdata; cap_wstrb = mem_wstrb; cap_we = mem_we;
        end
    end

    function automatic bit m_fault(input bit wr, input bit [2:0] f3, input bit [31:0] a);
        bit legal;
        int sz;
        legal = (f3 <= 3'd2) || (!wr && (f3 == 3'd4 || f3 == 3'd5));
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        return !legal || ((a % sz) != 0);
    endfunction

    function automatic logic [31:0] m_ext(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] r);
        logic [31:0] v;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (r >> (8 * a[1:0])) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            v = (r >> (16 * a[1])) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        end else v = r;
        return v;
    endfunction

    task automatic zero_exp();
        e_stall = 0; e_req = 0; e_we = 0; e_wstrb = 0; e_lv = 0; e_mf = 0; e_be = 0;
        e_ldchk = 0; e_ld = 0; e_addr = 0; e_wdata = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat: ACCESS cycle (1-based) carrying the ack; 0 or > T means no ack.
    task automatic do_instr(input bit rd, input bit wr, input bit [2:0] f3, input bit [31:0] a,
                            input bit [31:0] d2, input int lat, input bit [31:0] rdata);
        bit acked;
        int k;
        mem_read = rd; mem_write = wr; func_3 = f3; alu_out = a; data_2 = d2;
        zero_exp();
        e_mf = pend_mf; e_ldchk = pend_mf; pend_mf = 0;
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        if (!(rd || wr) || m_fault(wr, f3, a)) begin
            pend_mf = rd || wr;
            tick();
            return;
        end
        e_stall = 1;
        tick();
        e_mf = 0; e_ldchk = 0;
        e_req = 1; e_we = wr; e_addr = a & 32'hFFFF_FFFC;
        e_wstrb = !wr ? 4'h0 : (f3 == 3'd0) ? 4'(1 << a[1:0]) : (f3 == 3'd1) ? (a[1] ? 4'hC : 4'h3) : 4'hF;
        e_wdata = !wr ? 32'h0 : (f3 == 3'd0) ? (d2 & 32'hFF) * 32'h0101_0101 :
                  (f3 == 3'd1) ? (d2 & 32'hFFFF) * 32'h0001_0001 : d2;
        acked = 0;
        for (k = 1; k <= T && !acked; k++) begin
            acked = (k == lat);
            mem_ack = acked;
            mem_rdata = acked ? rdata : $urandom;
            tick();
        end
        zero_exp();
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        if (acked && !wr) begin e_lv = 1; e_ldchk = 1; e_ld = m_ext(f3, a, rdata); end
        if (!acked) begin e_be = 1; e_ldchk = 1; e_ld = 0; end
        tick();
    endtask

    task automatic nop();
        do_instr(0, 0, 3'd0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    int s_stall, s_req, s_lv, s_mf, s_be;
    task automatic snap();
        s_stall = stall_cnt; s_req = req_cnt; s_lv = lv_cnt; s_mf = mf_cnt; s_be = be_cnt;
    endtask

    initial begin
        zero_exp();
        tick();
        chk_en = 1;
        tick();
        rst = 0;
        nop();
        // LW 0x100, ack in the third ACCESS cycle
        snap();
        do_instr(1, 0, 3'd2, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        chk("lw_stall_cycles", 32'(stall_cnt - s_stall), 32'd4);
        chk("lw_load_data", cap_ld, 32'hDEADBEEF);
        chk("lw_valid_pulses", 32'(lv_cnt - s_lv), 32'd1);
        chk("lw_addr", cap_addr, 32'h100);
        chk("lw_wstrb", 32'(cap_wstrb), 32'h0);
        do_instr(1, 0, 3'd0, 32'h203, 32'h0, 1, 32'h80123456);
        chk("lb_sext", cap_ld, 32'hFFFFFF80);
        do_instr(1, 0, 3'd4, 32'h203, 32'h0, 1, 32'h80123456);
        chk("lbu_zext", cap_ld, 32'h00000080);
        do_instr(0, 1, 3'd1, 32'h102, 32'h1234ABCD, 2, 32'h0);
        chk("sh_we", 32'(cap_we), 32'h1);
        chk("sh_wstrb", 32'(cap_wstrb), 32'hC);
        chk("sh_wdata", cap_wdata, 32'hABCDABCD);
        chk("sh_addr", cap_addr, 32'h100);
        snap();
        do_instr(1, 0, 3'd2, 32'h101, 32'h0, 1, 32'h0);
        nop();
        chk("mis_req_cycles", 32'(req_cnt - s_req), 32'd0);
        chk("mis_stall_cycles", 32'(stall_cnt - s_stall), 32'd0);
        chk("mis_pulses", 32'(mf_cnt - s_mf), 32'd1);
        snap();
        do_instr(0, 1, 3'd2, 32'h40, 32'h55AA55AA, 0, 32'h0);
        chk("tmo_req_cycles", 32'(req_cnt - s_req), 32'(T));
        chk("tmo_pulses", 32'(be_cnt - s_be), 32'd1);
        // reset in the second ACCESS cycle, then a late ack
        snap();
        mem_read = 1; mem_write = 0; func_3 = 3'd2; alu_out = 32'h300; mem_ack = 0;
        zero_exp(); e_stall = 1;
        tick();
        zero_exp(); e_stall = 1; e_req = 1; e_addr = 32'h300;
        tick();
        rst = 1; e_stall = 0;
        tick();
        rst = 0; mem_read = 0; mem_ack = 1; mem_rdata = 32'h12345678;
        zero_exp();
        tick();
        tick();
        mem_ack = 0;
        nop();
        chk("rst_no_valid", 32'(lv_cnt - s_lv), 32'd0);
        snap();
        do_instr(1, 0, 3'd2, 32'h500, 32'h0, 1, 32'hCAFEF00D);
        do_instr(0, 1, 3'd2, 32'h504, 32'h01020304, 1, 32'h0);
        chk("b2b_req_cycles", 32'(req_cnt - s_req), 32'd2);
        chk("b2b_stall_cycles", 32'(stall_cnt - s_stall), 32'd4);
        for (int i = 0; i < 400; i++) begin
            bit [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     a, $urandom, $urandom_range(0, T + 1), $urandom);
        end
        nop();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
